// File: rtl/demux_sequencial.sv
// Registered 1-to-4 demux: routes D to channel {S1,S0} (MODO=0) or a round-robin pointer (MODO=1).
// Latency: 1 cycle from accept to Vk/Yk; a full channel drains and reloads on the same edge.
// Backpressure: IN_READY drops when the target channel is full and not being consumed.
module demux_sequencial #(
    parameter int WIDTH = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] D,
    input  logic             S0,
    input  logic             S1,
    input  logic             MODO,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] Y0,
    output logic [WIDTH-1:0] Y1,
    output logic [WIDTH-1:0] Y2,
    output logic [WIDTH-1:0] Y3,
    output logic             V0,
    output logic             V1,
    output logic             V2,
    output logic             V3,
    input  logic             R0,
    input  logic             R1,
    input  logic             R2,
    input  logic             R3,
    output logic [1:0]       CANAL
);

    logic [WIDTH-1:0] y_q [4];
    logic [3:0]       v_q;
    logic [1:0]       canal_q;
    logic [3:0]       r_vec;
    logic [1:0]       tgt;
    logic             accept;
    logic [3:0]       load;

    assign r_vec    = {R3, R2, R1, R0};
    assign tgt      = MODO ? canal_q : {S1, S0};
    assign IN_READY = !v_q[tgt] | r_vec[tgt];
    assign accept   = IN_VALID & IN_READY;
    assign load     = accept ? (4'b0001 << tgt) : 4'b0000;

    // Load wins over drain so a consumed channel can take a new word every cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < 4; k++) begin
                y_q[k] <= '0;
            end
            v_q <= 4'b0000;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    y_q[k] <= D;
                    v_q[k] <= 1'b1;
                end else if (v_q[k] && r_vec[k]) begin
                    v_q[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            canal_q <= 2'd0;
        end else if (accept && MODO) begin
            canal_q <= canal_q + 2'd1;
        end
    end

    assign Y0    = y_q[0];
    assign Y1    = y_q[1];
    assign Y2    = y_q[2];
    assign Y3    = y_q[3];
    assign V0    = v_q[0];
    assign V1    = v_q[1];
    assign V2    = v_q[2];
    assign V3    = v_q[3];
    assign CANAL = canal_q;

endmodule

// File: doc/demux_sequencial.md
Name: demux_sequencial

Overview:
- Registered 1-to-4 demultiplexer; the inverse of the team's 4:1 selector path.
- Routes one input word to one of four output channels.
- Each channel has a 1-entry holding buffer with a valid/ready handshake.
- The target channel comes either from select pins S1,S0 (direct mode) or from an internal round-robin pointer (distribution/deserialising mode).

Parameters:
- WIDTH, 1, data width of D and of each output Y0..Y3.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- D  input  WIDTH  input data word.
- S0  input  1  select LSB; used only when MODO=0.
- S1  input  1  select MSB; used only when MODO=0.
- MODO  input  1  0 = direct select {S1,S0}; 1 = round-robin pointer.
- IN_VALID  input  1  upstream has a word on D.
- IN_READY  output  1  block accepts D this cycle.
- Y0, Y1, Y2, Y3  output  WIDTH  channel data registers.
- V0, V1, V2, V3  output  1  channel k holds valid data.
- R0, R1, R2, R3  input  1  downstream of channel k consumes data.
- CANAL  output  2  current round-robin pointer value.

Behaviour:
- Reset (RST_N=0, asynchronous, independent of CLK):
  - Y0..Y3=0, V0..V3=0, CANAL=0.
  - IN_READY=1 while reset is held and after it releases.
  - Reset mid-transfer discards all buffered data with no partial state.
- Target channel T, combinational:
  - T = {S1,S0} when MODO=0; T = CANAL when MODO=1.
  - A MODO change takes effect in the same cycle. CANAL is not cleared on a mode change.
- IN_READY = !V[T] | R[T], combinational. No dependency on IN_VALID.
- Accept = IN_VALID & IN_READY. On the accepting edge: Y[T] <= D, V[T] <= 1.
- Latency: 1 cycle from accept to V[T]=1 with the new Y[T].
- Drain: on an edge with Vk=1 and Rk=1 and no load into k, Vk <= 0. Yk keeps its last value; it is not cleared.
- Simultaneous drain and load on the same channel:
  - Vk stays 1 and Yk takes the new D.
  - Sustains 1 word/cycle per channel when Rk is held at 1.
- Channels other than T are never written on an accept. Drains on all four channels proceed independently in the same cycle.
- Yk is stable while Vk=1 and Rk=0. Vk never drops without Rk=1.
- Rk while Vk=0 is ignored.
- Pointer:
  - In MODO=1, CANAL increments by 1 on every accepting edge and wraps 3 -> 0.
  - No increment without an accept.
  - In MODO=0, CANAL holds.
- Stall:
  - If V[T]=1 and R[T]=0, IN_READY=0 and nothing is written.
  - CANAL does not advance, so MODO=1 blocks on the pointed channel even if other channels are free.
- S0/S1 may change every cycle. Only their value at the accepting edge matters.
- No combinational path from D to any output. Y/V are register outputs.

Test Plan:
1. Reset and idle: hold RST_N=0 mid-cycle with V2=1 -> all Y=0, V=0, CANAL=0 immediately; after release IN_READY=1.
2. Direct mode, WIDTH=4, R0..R3=0, MODO=0: send D=0xA,S=00; D=0x5,S=11 -> Y0=0xA,V0=1 one cycle after the first accept; Y3=0x5,V3=1; V1=V2=0; CANAL stays 0.
3. Backpressure, MODO=0, S=01, R1=0: two back-to-back words 0x3, 0x7 -> 0x3 lands in Y1; IN_READY=0 with 0x7 pending; raise R1 -> 0x7 overwrites Y1 on the same edge V1 would drop, V1 stays 1.
4. Round-robin, MODO=1, all Rk=1: 6 consecutive words 1..6 -> land in Y0,Y1,Y2,Y3,Y0,Y1 at one word/cycle; CANAL sequence 0,1,2,3,0,1,2 (wrap verified).
5. Round-robin stall, MODO=1, CANAL=2, V2=1, R2=0, other channels empty -> IN_READY=0, CANAL holds at 2; on R2=1 the accept proceeds and CANAL=3.
6. Mode switch, MODO=1 with CANAL=1, then MODO=0 with S=10 and one word -> word goes to Y2, CANAL stays 1; back to MODO=1 -> next word goes to Y1.
